// File: rtl/opl3_timers_pkg.sv
// Shared types and constants for the OPL3 Timer 1 / Timer 2 block.
package opl3_timers_pkg;

  localparam int TIMER1_PRESCALE = 4;
  localparam int TIMER2_PRESCALE = 16;

  localparam logic [7:0] TIMER1_ADDR     = 8'h02;
  localparam logic [7:0] TIMER2_ADDR     = 8'h03;
  localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

  // Bit positions inside the timer control register (0x04)
  localparam int IRQ_RESET_BIT = 7;
  localparam int MASK1_BIT     = 6;
  localparam int MASK2_BIT     = 5;
  localparam int ST2_BIT       = 1;
  localparam int ST1_BIT       = 0;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

endpackage

// File: rtl/opl3_timers_if.sv
// Register-write stream, sample pacing and status/IRQ signals of the timer block.
interface opl3_timers_if;
  import opl3_timers_pkg::*;

  opl3_reg_wr_t opl3_reg_wr;
  logic         sample_clk_en;
  logic         force_timer_overflow;
  logic [7:0]   status;
  logic         irq_n;

  modport master (
    output opl3_reg_wr, sample_clk_en, force_timer_overflow,
    input  status, irq_n
  );

  modport slave (
    input  opl3_reg_wr, sample_clk_en, force_timer_overflow,
    output status, irq_n
  );
endinterface

// File: rtl/opl3_timers_counter.sv
// One OPL3 timer: prescaler plus 8-bit up-counter that reloads its preset on overflow.
module opl3_timer_counter #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       ic_n,
  input  logic       sample_clk_en,
  input  logic       start,
  input  logic [7:0] preset,
  output logic       overflow
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  logic          r_start_d;
  logic [PW-1:0] r_prescale;
  logic [7:0]    r_count;
  logic          w_start_edge;
  logic          w_tick;

  // The cycle after start rises is spent loading, so a pulse landing there is not counted
  assign w_start_edge = start & ~r_start_d;
  assign w_tick       = start & ~w_start_edge & sample_clk_en & (r_prescale == PS_LAST);
  assign overflow     = w_tick & (r_count == 8'hFF);

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      r_start_d  <= 1'b0;
      r_prescale <= '0;
      r_count    <= 8'h00;
    end else begin
      r_start_d <= start;
      if (w_start_edge) begin
        r_count    <= preset;
        r_prescale <= '0;
      end else if (start && sample_clk_en) begin
        if (r_prescale == PS_LAST) begin
          r_prescale <= '0;
          r_count    <= (r_count == 8'hFF) ? preset : r_count + 8'd1;
        end else begin
          r_prescale <= r_prescale + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/opl3_timers.sv
// OPL3 timer block: register decode, overflow flags, masks, status byte and IRQ.
module opl3_timers
  import opl3_timers_pkg::*;
(
  input  logic           clk,
  input  logic           ic_n,
  opl3_timers_if.slave   bus
);

  logic [7:0] r_preset1, r_preset2;
  logic       r_st1, r_st2, r_mask1, r_mask2;
  logic       r_ft1, r_ft2;
  logic [7:0] r_status;
  logic       r_irq_n;

  logic       w_bank0_wr, w_ctrl_wr, w_irq_clr;
  logic       w_ovf1, w_ovf2, w_set1, w_set2;

  assign w_bank0_wr = bus.opl3_reg_wr.valid & ~bus.opl3_reg_wr.bank_num;
  assign w_ctrl_wr  = w_bank0_wr & (bus.opl3_reg_wr.address == TIMER_CTRL_ADDR);
  assign w_irq_clr  = w_ctrl_wr & bus.opl3_reg_wr.data[IRQ_RESET_BIT];

  opl3_timer_counter #(.PRESCALE(TIMER1_PRESCALE)) u_timer1 (
    .clk(clk), .ic_n(ic_n), .sample_clk_en(bus.sample_clk_en),
    .start(r_st1), .preset(r_preset1), .overflow(w_ovf1)
  );

  opl3_timer_counter #(.PRESCALE(TIMER2_PRESCALE)) u_timer2 (
    .clk(clk), .ic_n(ic_n), .sample_clk_en(bus.sample_clk_en),
    .start(r_st2), .preset(r_preset2), .overflow(w_ovf2)
  );

  // Set sources outrank a simultaneous IRQ-reset write
  assign w_set1 = (w_ovf1 & ~r_mask1) | bus.force_timer_overflow;
  assign w_set2 = (w_ovf2 & ~r_mask2) | bus.force_timer_overflow;

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      r_preset1 <= 8'h00;
      r_preset2 <= 8'h00;
      r_st1     <= 1'b0;
      r_st2     <= 1'b0;
      r_mask1   <= 1'b0;
      r_mask2   <= 1'b0;
      r_ft1     <= 1'b0;
      r_ft2     <= 1'b0;
      r_status  <= 8'h00;
      r_irq_n   <= 1'b1;
    end else begin
      if (w_bank0_wr && bus.opl3_reg_wr.address == TIMER1_ADDR)
        r_preset1 <= bus.opl3_reg_wr.data;
      if (w_bank0_wr && bus.opl3_reg_wr.address == TIMER2_ADDR)
        r_preset2 <= bus.opl3_reg_wr.data;
      if (w_ctrl_wr && !bus.opl3_reg_wr.data[IRQ_RESET_BIT]) begin
        r_mask1 <= bus.opl3_reg_wr.data[MASK1_BIT];
        r_mask2 <= bus.opl3_reg_wr.data[MASK2_BIT];
        r_st1   <= bus.opl3_reg_wr.data[ST1_BIT];
        r_st2   <= bus.opl3_reg_wr.data[ST2_BIT];
      end

      if (w_set1)         r_ft1 <= 1'b1;
      else if (w_irq_clr) r_ft1 <= 1'b0;
      if (w_set2)         r_ft2 <= 1'b1;
      else if (w_irq_clr) r_ft2 <= 1'b0;

      r_status <= {r_ft1 | r_ft2, r_ft1, r_ft2, 5'b00000};
      r_irq_n  <= ~(r_ft1 | r_ft2);
    end
  end

  assign bus.status = r_status;
  assign bus.irq_n  = r_irq_n;

endmodule
